// File: rtl/vec_stream_loader_if.sv
// Host-side bundle for vec_stream_loader: command and element stream in, and
// the bank write port plus status out.
interface vec_stream_loader_if #(
  parameter int unsigned BITS = 8,
  parameter int unsigned N    = 64
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [3:0]      cmd_reg;
  logic            s_valid;
  logic            s_ready;
  logic [BITS-1:0] s_data;
  logic [BITS-1:0] vec_out [N];
  logic [3:0]      wr_sel;
  logic            wr_en;
  logic            busy;
  logic            done;

  modport master (
    output cmd_valid, cmd_reg, s_valid, s_data,
    input  cmd_ready, s_ready, vec_out, wr_sel, wr_en, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_reg, s_valid, s_data,
    output cmd_ready, s_ready, vec_out, wr_sel, wr_en, busy, done
  );
endinterface

// File: rtl/vec_stream_loader.sv
// Collects N stream elements into a vector, then strobes a single parallel
// write of that vector into the selected vector-bank register.
module vec_stream_loader #(
  parameter int unsigned BITS = 8,
  parameter int unsigned N    = 64
) (
  input logic               clk,
  input logic               rst,
  vec_stream_loader_if.slave bus_io
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [BITS-1:0] vec_q [N];
  logic [3:0]      wr_sel_q;
  logic            wr_en_q;
  logic            done_q;
  logic            busy_q;
  logic            cmd_ready_q;
  logic            s_ready_q;

  // Handshake outputs are registered alongside the state so that no output
  // depends combinationally on an input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      for (int i = 0; i < int'(N); i++) begin
        vec_q[i] <= '0;
      end
      wr_sel_q    <= '0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      s_ready_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.cmd_valid) begin
            wr_sel_q    <= bus_io.cmd_reg;
            cnt_q       <= '0;
            state_q     <= StLoad;
            cmd_ready_q <= 1'b0;
            s_ready_q   <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StLoad: begin
          if (bus_io.s_valid) begin
            vec_q[cnt_q] <= bus_io.s_data;
            if (cnt_q == LastIdx) begin
              state_q   <= StWrite;
              s_ready_q <= 1'b0;
              wr_en_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StWrite: begin
          state_q     <= StIdle;
          done_q      <= 1'b1;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
          s_ready_q   <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_vec_out
    assign bus_io.vec_out[g] = vec_q[g];
  end

  assign bus_io.wr_sel    = wr_sel_q;
  assign bus_io.wr_en     = wr_en_q;
  assign bus_io.done      = done_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.cmd_ready = cmd_ready_q;
  assign bus_io.s_ready   = s_ready_q;

  // The write strobe is a single-cycle pulse always followed by done.
  a_wr_en_pulse : assert property (@(posedge clk) disable iff (rst)
    wr_en_q |=> (!wr_en_q && done_q));

  a_ready_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(cmd_ready_q && s_ready_q));

endmodule

// File: tb/tb_vec_stream_loader.sv
// Directed bench for vec_stream_loader: an N=64 instance for the main flows and
// an N=4 instance for the reset-during-load case, each feeding a small bank model.
module tb_vec_stream_loader;

  logic clk = 1'b0;
  logic rst64;
  logic rst4;

  always #5 clk = ~clk;

  vec_stream_loader_if #(.BITS(8), .N(64)) if64 ();
  vec_stream_loader_if #(.BITS(8), .N(4))  if4 ();

  vec_stream_loader #(.BITS(8), .N(64)) dut64 (
    .clk    (clk),
    .rst    (rst64),
    .bus_io (if64)
  );

  vec_stream_loader #(.BITS(8), .N(4)) dut4 (
    .clk    (clk),
    .rst    (rst4),
    .bus_io (if4)
  );

  // Bank models: capture the vector on the edge that ends the wr_en cycle.
  logic [7:0] bank64 [16][64];
  logic [7:0] bank4  [16][4];
  int         wr_cnt64 = 0;
  int         wr_cnt4  = 0;
  int         reg_wr64 [16] = '{default: 0};

  always @(posedge clk) begin
    if (if64.wr_en === 1'b1) begin
      wr_cnt64 <= wr_cnt64 + 1;
      reg_wr64[if64.wr_sel] <= reg_wr64[if64.wr_sel] + 1;
      for (int i = 0; i < 64; i++) bank64[if64.wr_sel][i] <= if64.vec_out[i];
    end
    if (if4.wr_en === 1'b1) begin
      wr_cnt4 <= wr_cnt4 + 1;
      for (int i = 0; i < 4; i++) bank4[if4.wr_sel][i] <= if4.vec_out[i];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int base;
    int bad;
    rst64 = 1'b0;
    if64.cmd_valid = 1'b1;
    if64.cmd_reg   = 4'd7;
    tick();
    if64.cmd_valid = 1'b0;
    if64.s_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if64.s_data = 8'hC0 + 8'(i);
      tick();
    end
    n_checks++;
    if (if64.vec_out[3] !== 8'hC3) begin
      n_fail++; $display("FAIL rst_pre_elem3: got %h want c3", if64.vec_out[3]);
    end
    base  = wr_cnt64;
    rst64 = 1'b1;
    tick();
    tick();
    rst64 = 1'b0;
    if64.s_valid = 1'b0;
    n_checks++;
    if (if64.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", if64.cmd_ready);
    end
    n_checks++;
    if (if64.s_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_s_ready: got %b want 0", if64.s_ready);
    end
    n_checks++;
    if (if64.busy !== 1'b0 || if64.wr_en !== 1'b0 || if64.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_status: got busy=%b wr_en=%b done=%b want 0 0 0",
               if64.busy, if64.wr_en, if64.done);
    end
    n_checks++;
    if (if64.wr_sel !== 4'd0) begin
      n_fail++; $display("FAIL rst_wr_sel: got %0d want 0", if64.wr_sel);
    end
    bad = -1;
    for (int i = 0; i < 64; i++) if (bad < 0 && if64.vec_out[i] !== 8'h00) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++; $display("FAIL rst_vec_zero: elem %0d got %h want 00", bad, if64.vec_out[bad]);
    end
    for (int i = 0; i < 70; i++) tick();
    n_checks++;
    if (wr_cnt64 - base !== 0) begin
      n_fail++; $display("FAIL rst_no_write: got %0d writes want 0", wr_cnt64 - base);
    end
  endtask

  task automatic test_basic();
    int base;
    int bad;
    base = wr_cnt64;
    if64.cmd_valid = 1'b1;
    if64.cmd_reg   = 4'd5;
    tick();
    if64.cmd_valid = 1'b0;
    if64.s_valid   = 1'b1;
    n_checks++;
    if (if64.busy !== 1'b1 || if64.s_ready !== 1'b1 || if64.cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_load_state: got busy=%b s_ready=%b cmd_ready=%b want 1 1 0",
               if64.busy, if64.s_ready, if64.cmd_ready);
    end
    for (int i = 0; i < 64; i++) begin
      if64.s_data = 8'(i);
      tick();
    end
    if64.s_valid = 1'b0;
    n_checks++;
    if (if64.wr_en !== 1'b1 || if64.wr_sel !== 4'd5) begin
      n_fail++;
      $display("FAIL basic_wr_cycle65: got wr_en=%b wr_sel=%0d want 1 5", if64.wr_en, if64.wr_sel);
    end
    bad = -1;
    for (int i = 0; i < 64; i++) if (bad < 0 && if64.vec_out[i] !== 8'(i)) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++; $display("FAIL basic_vec: elem %0d got %h want %h", bad, if64.vec_out[bad], 8'(bad));
    end
    tick();
    n_checks++;
    if (if64.done !== 1'b1 || if64.cmd_ready !== 1'b1 || if64.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_cycle66: got done=%b cmd_ready=%b wr_en=%b want 1 1 0",
               if64.done, if64.cmd_ready, if64.wr_en);
    end
    bad = -1;
    for (int i = 0; i < 64; i++) if (bad < 0 && bank64[5][i] !== 8'(i)) bad = i;
    n_checks++;
    if (bad >= 0 || wr_cnt64 - base !== 1) begin
      n_fail++; $display("FAIL basic_bank5: bad elem %0d, writes %0d want none bad, 1", bad,
                         wr_cnt64 - base);
    end
    tick();
    n_checks++;
    if (if64.done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: got %b want 0", if64.done);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int idx;
    int cyc;
    int gaps;
    int bad;
    base = wr_cnt64;
    if64.cmd_valid = 1'b1;
    if64.cmd_reg   = 4'd15;
    tick();
    if64.cmd_valid = 1'b0;
    idx  = 0;
    cyc  = 0;
    gaps = 0;
    while (idx < 64 && cyc < 200) begin
      if (cyc % 3 == 2) begin
        if64.s_valid = 1'b0;
        if64.s_data  = 8'hFF;
        gaps++;
      end else begin
        if64.s_valid = 1'b1;
        if64.s_data  = 8'(idx);
        idx++;
      end
      if (idx == 64) begin
        n_checks++;
        if (if64.wr_en !== 1'b0) begin
          n_fail++; $display("FAIL bp_early_wr: got %b want 0", if64.wr_en);
        end
      end
      tick();
      cyc++;
    end
    if64.s_valid = 1'b0;
    // 64 elements with a gap every third cycle: 31 gaps, 95 stream cycles.
    n_checks++;
    if (gaps !== 31 || if64.wr_en !== 1'b1 || if64.wr_sel !== 4'd15) begin
      n_fail++;
      $display("FAIL bp_wr_cycle: got gaps=%0d wr_en=%b wr_sel=%0d want 31 1 15",
               gaps, if64.wr_en, if64.wr_sel);
    end
    tick();
    tick();
    bad = -1;
    for (int i = 0; i < 64; i++) if (bad < 0 && bank64[15][i] !== 8'(i)) bad = i;
    n_checks++;
    if (bad >= 0 || wr_cnt64 - base !== 1) begin
      n_fail++; $display("FAIL bp_bank15: bad elem %0d, writes %0d want none bad, 1", bad,
                         wr_cnt64 - base);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    if64.cmd_valid = 1'b1;
    if64.cmd_reg   = 4'd2;
    tick();
    if64.cmd_reg = 4'd3;
    if64.s_valid = 1'b1;
    if64.s_data  = 8'hAA;
    for (int i = 0; i < 64; i++) tick();
    if64.s_valid = 1'b0;
    n_checks++;
    if (if64.wr_en !== 1'b1 || if64.wr_sel !== 4'd2) begin
      n_fail++; $display("FAIL b2b_first_wr: got wr_en=%b wr_sel=%0d want 1 2",
                         if64.wr_en, if64.wr_sel);
    end
    tick();
    n_checks++;
    if (if64.done !== 1'b1 || if64.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: got done=%b cmd_ready=%b want 1 1",
                         if64.done, if64.cmd_ready);
    end
    tick();
    if64.cmd_valid = 1'b0;
    if64.s_valid   = 1'b1;
    if64.s_data    = 8'h55;
    n_checks++;
    if (if64.busy !== 1'b1 || if64.s_ready !== 1'b1 || if64.wr_sel !== 4'd3) begin
      n_fail++; $display("FAIL b2b_second_accept: got busy=%b s_ready=%b wr_sel=%0d want 1 1 3",
                         if64.busy, if64.s_ready, if64.wr_sel);
    end
    for (int i = 0; i < 64; i++) tick();
    if64.s_valid = 1'b0;
    n_checks++;
    if (if64.wr_en !== 1'b1 || if64.wr_sel !== 4'd3) begin
      n_fail++; $display("FAIL b2b_second_wr: got wr_en=%b wr_sel=%0d want 1 3",
                         if64.wr_en, if64.wr_sel);
    end
    tick();
    bad = -1;
    for (int i = 0; i < 64; i++) begin
      if (bad < 0 && (bank64[2][i] !== 8'hAA || bank64[3][i] !== 8'h55)) bad = i;
    end
    n_checks++;
    if (bad >= 0) begin
      n_fail++; $display("FAIL b2b_bank: elem %0d got r2=%h r3=%h want aa 55", bad,
                         bank64[2][bad], bank64[3][bad]);
    end
  endtask

  task automatic test_ignored();
    int base;
    int bad;
    base = wr_cnt64;
    if64.s_valid = 1'b1;
    if64.s_data  = 8'h77;
    tick();
    tick();
    tick();
    n_checks++;
    if (if64.s_ready !== 1'b0 || if64.busy !== 1'b0 || if64.vec_out[0] !== 8'h55) begin
      n_fail++; $display("FAIL ign_idle_stream: got s_ready=%b busy=%b elem0=%h want 0 0 55",
                         if64.s_ready, if64.busy, if64.vec_out[0]);
    end
    if64.cmd_valid = 1'b1;
    if64.cmd_reg   = 4'd4;
    tick();
    if64.cmd_reg = 4'd9;
    for (int i = 0; i < 64; i++) begin
      if64.s_data = 8'h40 + 8'(i);
      tick();
    end
    if64.s_valid   = 1'b0;
    if64.cmd_valid = 1'b0;
    n_checks++;
    if (if64.wr_en !== 1'b1 || if64.wr_sel !== 4'd4) begin
      n_fail++; $display("FAIL ign_wr: got wr_en=%b wr_sel=%0d want 1 4", if64.wr_en, if64.wr_sel);
    end
    bad = -1;
    for (int i = 0; i < 64; i++) if (bad < 0 && if64.vec_out[i] !== 8'h40 + 8'(i)) bad = i;
    n_checks++;
    if (bad >= 0) begin
      n_fail++; $display("FAIL ign_vec: elem %0d got %h want %h", bad, if64.vec_out[bad],
                         8'h40 + 8'(bad));
    end
    for (int i = 0; i < 5; i++) tick();
    n_checks++;
    if (wr_cnt64 - base !== 1 || reg_wr64[9] !== 0 || if64.busy !== 1'b0) begin
      n_fail++; $display("FAIL ign_single_write: got writes=%0d r9writes=%0d busy=%b want 1 0 0",
                         wr_cnt64 - base, reg_wr64[9], if64.busy);
    end
  endtask

  task automatic test_reset_midload();
    int base;
    int bad;
    base = wr_cnt4;
    if4.cmd_valid = 1'b1;
    if4.cmd_reg   = 4'd6;
    tick();
    if4.cmd_valid = 1'b0;
    if4.s_valid   = 1'b1;
    if4.s_data    = 8'h09;
    tick();
    if4.s_data = 8'h08;
    tick();
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    if4.s_valid = 1'b0;
    n_checks++;
    if (if4.busy !== 1'b0 || if4.cmd_ready !== 1'b1 || if4.vec_out[0] !== 8'h00 ||
        if4.vec_out[1] !== 8'h00 || if4.wr_sel !== 4'd0) begin
      n_fail++; $display("FAIL rml_reset_vals: got busy=%b cmd_ready=%b e0=%h e1=%h sel=%0d",
                         if4.busy, if4.cmd_ready, if4.vec_out[0], if4.vec_out[1], if4.wr_sel);
    end
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (wr_cnt4 - base !== 0 || if4.done !== 1'b0) begin
      n_fail++; $display("FAIL rml_no_write: got writes=%0d done=%b want 0 0",
                         wr_cnt4 - base, if4.done);
    end
    if4.cmd_valid = 1'b1;
    if4.cmd_reg   = 4'd1;
    tick();
    if4.cmd_valid = 1'b0;
    if4.s_valid   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if4.s_data = 8'(i + 1);
      tick();
    end
    if4.s_valid = 1'b0;
    n_checks++;
    if (if4.wr_en !== 1'b1 || if4.wr_sel !== 4'd1) begin
      n_fail++; $display("FAIL rml_wr: got wr_en=%b wr_sel=%0d want 1 1", if4.wr_en, if4.wr_sel);
    end
    tick();
    bad = -1;
    for (int i = 0; i < 4; i++) if (bad < 0 && bank4[1][i] !== 8'(i + 1)) bad = i;
    n_checks++;
    if (bad >= 0 || wr_cnt4 - base !== 1 || if4.done !== 1'b1) begin
      n_fail++; $display("FAIL rml_bank1: bad elem %0d writes=%0d done=%b want none 1 1",
                         bad, wr_cnt4 - base, if4.done);
    end
  endtask

  initial begin
    rst64 = 1'b1;
    rst4  = 1'b1;
    if64.cmd_valid = 1'b0;
    if64.cmd_reg   = 4'd0;
    if64.s_valid   = 1'b0;
    if64.s_data    = 8'h00;
    if4.cmd_valid  = 1'b0;
    if4.cmd_reg    = 4'd0;
    if4.s_valid    = 1'b0;
    if4.s_data     = 8'h00;
    tick();
    tick();
    rst4 = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_ignored();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_stream_loader.md
# vec_stream_loader

Deserialising write-side front end for the vector register bank. It accepts a command naming a target vector register, collects N elements one at a time over a valid/ready stream from the host interface, then issues a single-cycle parallel write of the assembled vector into the bank. It drives the bank's data_in, in_sel and write inputs directly, and reports completion back to the host-side controller.

## Interface
- BITS, default 8: width of one vector element.
- N, default 64: elements per vector; the element counter width is $clog2(N).
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  a load command is offered.
- cmd_ready  out  1  loader can accept a command; high only in IDLE.
- cmd_reg  in  4  target register index, sampled on command accept.
- s_valid  in  1  stream element offered.
- s_ready  out  1  loader accepts an element; high only in LOAD.
- s_data  in  BITS  stream element, sampled on element accept.
- vec_out  out  BITS x [N] unpacked  assembled vector, element i at index i; feeds bank data_in.
- wr_sel  out  4  latched target index; feeds bank in_sel.
- wr_en  out  1  one-cycle write strobe; feeds bank write.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse, the cycle after wr_en.

## Operation
- States: IDLE, LOAD, WRITE.
- IDLE: cmd_ready=1. When cmd_valid=1, latch cmd_reg into wr_sel, clear cnt to 0, go to LOAD. s_valid is ignored in IDLE; no element is consumed.
- LOAD: s_ready=1. On s_valid&&s_ready, write s_data into vec_out[cnt] and increment cnt.
  - When the accepted element has cnt==N-1, go to WRITE. cnt does not wrap past N-1.
  - cmd_valid is ignored in LOAD and WRITE; cmd_reg is not re-sampled.
- WRITE: wr_en=1 for exactly one cycle. vec_out and wr_sel are stable during this cycle. Next state is IDLE, with done=1 registered for that first IDLE cycle.
- vec_out holds the last assembled vector until overwritten element by element in a later LOAD. Elements not yet written in the current LOAD keep their old values, but no write is issued until all N have been replaced.
- Reset values: state IDLE, cnt 0, every vec_out element 0, wr_sel 0, wr_en 0, done 0, busy 0, cmd_ready 1, s_ready 0.
- Reset mid-LOAD or mid-WRITE takes effect on the next edge. Any partial vector is discarded, no wr_en is issued afterwards, and done is not asserted.
- A command may be accepted in the same cycle done=1, because that cycle is IDLE.

## Timing
- Cycle 0: command accepted. Cycles 1..N: LOAD with s_valid held high, one element per cycle. Cycle N+1: wr_en=1. Cycle N+2: done=1 and cmd_ready=1.
- Each low-s_valid cycle during LOAD adds one cycle to this sequence. There is no timeout.
- Minimum command-to-command spacing is N+2 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.
- The bank captures vec_out on the edge that ends the wr_en cycle.

## Test plan
- Reset: assert rst 2 cycles mid-stream -> all outputs at the reset values above; vec_out all 0.
- Basic load, N=64: cmd_reg=5, stream s_data=i for i=0..63, s_valid constant -> wr_en at cycle 65 with wr_sel=5 and vec_out[i]=i; done at cycle 66; bank register 5 reads back 0..63.
- Backpressure gaps: s_valid low on every third cycle, cmd_reg=15 -> same vector captured, wr_en delayed by the number of gap cycles, exactly one wr_en.
- Back-to-back: cmd_reg=2 with data 0xAA, cmd_valid held high, then cmd_reg=3 with data 0x55 -> second command accepted in the done cycle; registers 2 and 3 hold 0xAA and 0x55; register 2 is not disturbed.
- Ignored inputs: s_valid=1 while IDLE, and cmd_valid=1 with cmd_reg=9 during LOAD of register 4 -> no element consumed, wr_sel stays 4, no extra write.
- Reset mid-load, N=4: reset after 2 of 4 elements -> no wr_en; a following full load of register 1 with 1,2,3,4 writes exactly 1,2,3,4.
